// File: rtl/reg_file_mp_pkg.sv
// Shared definitions for the multi-port register file:
// default geometry and the clear-engine state encoding.
package reg_file_mp_pkg;

    localparam int DSIZE_DEF = 16;
    localparam int RSIZE_DEF = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } rf_state_e;

endpackage

// File: rtl/reg_file_mp_rf_init_seq.sv
// Array-clear sequencer: walks every entry once after reset
// or an accepted Clear, then raises Ready.
module rf_init_seq
    import reg_file_mp_pkg::*;
#(
    parameter int RSIZE = RSIZE_DEF
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Clear,
    output logic             Ready,
    output logic             clr_we,
    output logic [RSIZE-1:0] clr_addr
);

    localparam int DEPTH = 2 ** RSIZE;
    localparam int IW    = RSIZE + 1;

    rf_state_e state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_CLEAR: begin
                idx_d = idx_q + IW'(1);
                if (idx_q == IW'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (Clear) begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_CLEAR;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign Ready    = (state_q == ST_IDLE);
    assign clr_we   = (state_q == ST_CLEAR);
    assign clr_addr = idx_q[RSIZE-1:0];

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with byte-masked writes, write-first
// bypass, optional hardwired-zero entry 0 and a clear engine.
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int DSIZE    = DSIZE_DEF,
    parameter int RSIZE    = RSIZE_DEF,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Clear,
    output logic                   Ready,
    input  logic                   Wen,
    input  logic [RSIZE-1:0]       WAddr,
    input  logic [DSIZE-1:0]       WData,
    input  logic [DSIZE/8-1:0]     WMask,
    input  logic [NRD*RSIZE-1:0]   RAddr,
    output logic [NRD*DSIZE-1:0]   RData
);

    localparam int DEPTH = 2 ** RSIZE;
    localparam int NB    = DSIZE / 8;

    function automatic logic [DSIZE-1:0] merge_bytes(
        input logic [DSIZE-1:0] old_v,
        input logic [DSIZE-1:0] new_v,
        input logic [NB-1:0]    mask
    );
        logic [DSIZE-1:0] r;
        r = old_v;
        for (int b = 0; b < NB; b++) begin
            if (mask[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

    logic             clr_we;
    logic [RSIZE-1:0] clr_addr;
    logic             usr_ok;
    logic             wr_ok;
    logic             zero_hit;
    logic [DSIZE-1:0] mem_q [DEPTH];

    rf_init_seq #(
        .RSIZE (RSIZE)
    ) u_init (
        .Clock    (Clock),
        .Reset    (Reset),
        .Clear    (Clear),
        .Ready    (Ready),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // An accepted Clear swallows any write in the same cycle.
    assign usr_ok   = Ready && !Clear && !Reset;
    assign zero_hit = (ZERO_REG != 0) && (WAddr == '0);
    assign wr_ok    = usr_ok && Wen && (|WMask) && !zero_hit;

    always_ff @(posedge Clock) begin
        if (clr_we && !Reset) begin
            mem_q[clr_addr] <= '0;
        end else if (wr_ok) begin
            mem_q[WAddr] <= merge_bytes(mem_q[WAddr], WData, WMask);
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [RSIZE-1:0] ra;
        logic [DSIZE-1:0] rd_d, rd_q;

        assign ra = RAddr[p*RSIZE +: RSIZE];

        always_comb begin
            rd_d = mem_q[ra];
            if (wr_ok && (WAddr == ra)) begin
                rd_d = merge_bytes(mem_q[ra], WData, WMask);
            end
            if (!usr_ok || ((ZERO_REG != 0) && (ra == '0))) begin
                rd_d = '0;
            end
        end

        always_ff @(posedge Clock) begin
            if (Reset) begin
                rd_q <= '0;
            end else begin
                rd_q <= rd_d;
            end
        end

        assign RData[p*DSIZE +: DSIZE] = rd_q;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench: two instances (ZERO_REG=1 and 0) share inputs
// and are compared against an array-based reference model.
module tb_reg_file_mp;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Clear = 1'b0;
    logic        Wen   = 1'b0;
    logic [3:0]  WAddr = '0;
    logic [15:0] WData = '0;
    logic [1:0]  WMask = '0;
    logic [7:0]  RAddr = '0;
    logic        rdy1, rdy0;
    logic [31:0] rd1, rd0;

    int n_cmp = 0;
    int n_bad = 0;

    reg_file_mp #(.DSIZE(16), .RSIZE(4), .NRD(2), .ZERO_REG(1)) dut (
        .Clock(Clock), .Reset(Reset), .Clear(Clear), .Ready(rdy1),
        .Wen(Wen), .WAddr(WAddr), .WData(WData), .WMask(WMask),
        .RAddr(RAddr), .RData(rd1)
    );

    reg_file_mp #(.DSIZE(16), .RSIZE(4), .NRD(2), .ZERO_REG(0)) dut0 (
        .Clock(Clock), .Reset(Reset), .Clear(Clear), .Ready(rdy0),
        .Wen(Wen), .WAddr(WAddr), .WData(WData), .WMask(WMask),
        .RAddr(RAddr), .RData(rd0)
    );

    always #5 Clock = ~Clock;

    // Reference model: z=1 is the zero-register instance.
    int          clr_left = 16;
    logic [15:0] mm [2][16];
    logic [15:0] er [2][2];

    task automatic model_step();
        if (Reset || (clr_left == 0 && Clear)) begin
            clr_left = 16;
            for (int z = 0; z < 2; z++) begin
                for (int i = 0; i < 16; i++) mm[z][i] = '0;
                er[z][0] = '0;
                er[z][1] = '0;
            end
        end else if (clr_left > 0) begin
            clr_left--;
            for (int z = 0; z < 2; z++) begin
                er[z][0] = '0;
                er[z][1] = '0;
            end
        end else begin
            for (int z = 0; z < 2; z++) begin
                if (Wen && !(z == 1 && WAddr == 4'd0)) begin
                    for (int b = 0; b < 2; b++) begin
                        if (WMask[b]) mm[z][WAddr][8*b +: 8] = WData[8*b +: 8];
                    end
                end
                for (int p = 0; p < 2; p++) begin
                    logic [3:0] a;
                    a = RAddr[4*p +: 4];
                    er[z][p] = (z == 1 && a == 4'd0) ? 16'h0 : mm[z][a];
                end
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("ready_z1", {31'd0, rdy1}, {31'd0, clr_left == 0});
        chk("ready_z0", {31'd0, rdy0}, {31'd0, clr_left == 0});
        chk("rd_z1_p0", {16'd0, rd1[15:0]},  {16'd0, er[1][0]});
        chk("rd_z1_p1", {16'd0, rd1[31:16]}, {16'd0, er[1][1]});
        chk("rd_z0_p0", {16'd0, rd0[15:0]},  {16'd0, er[0][0]});
        chk("rd_z0_p1", {16'd0, rd0[31:16]}, {16'd0, er[0][1]});
    endtask

    task automatic cyc(input logic rst, input logic clr, input logic we,
                       input logic [3:0] wa, input logic [15:0] wd,
                       input logic [1:0] wm, input logic [3:0] a0,
                       input logic [3:0] a1);
        Reset = rst;
        Clear = clr;
        Wen   = we;
        WAddr = wa;
        WData = wd;
        WMask = wm;
        RAddr = {a1, a0};
        @(posedge Clock);
        model_step();
        #1;
        check_model();
    endtask

    task automatic idle(input logic [3:0] a0, input logic [3:0] a1);
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 2'b00, a0, a1);
    endtask

    typedef struct {
        logic        wen;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic [1:0]  wm;
        logic [3:0]  a0;
        logic [3:0]  a1;
        logic [15:0] e0;
        logic [15:0] e1;
        logic [15:0] x0;
    } vec_t;

    vec_t vt [11];

    initial begin
        vt[0]  = '{1'b1, 4'd3, 16'hA5A5, 2'b11, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000};
        vt[1]  = '{1'b0, 4'd0, 16'h0000, 2'b00, 4'd3, 4'd3, 16'hA5A5, 16'hA5A5, 16'hA5A5};
        vt[2]  = '{1'b1, 4'd5, 16'hFFFF, 2'b11, 4'd3, 4'd5, 16'hA5A5, 16'hFFFF, 16'hA5A5};
        vt[3]  = '{1'b1, 4'd5, 16'h1234, 2'b01, 4'd5, 4'd5, 16'hFF34, 16'hFF34, 16'hFF34};
        vt[4]  = '{1'b0, 4'd0, 16'h0000, 2'b00, 4'd5, 4'd3, 16'hFF34, 16'hA5A5, 16'hFF34};
        vt[5]  = '{1'b1, 4'd7, 16'h00C3, 2'b11, 4'd7, 4'd0, 16'h00C3, 16'h0000, 16'h00C3};
        vt[6]  = '{1'b0, 4'd0, 16'h0000, 2'b00, 4'd7, 4'd7, 16'h00C3, 16'h00C3, 16'h00C3};
        vt[7]  = '{1'b1, 4'd0, 16'hBEEF, 2'b11, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'hBEEF};
        vt[8]  = '{1'b0, 4'd0, 16'h0000, 2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'hBEEF};
        vt[9]  = '{1'b1, 4'd3, 16'h0000, 2'b00, 4'd3, 4'd3, 16'hA5A5, 16'hA5A5, 16'hA5A5};
        vt[10] = '{1'b1, 4'd3, 16'h5A00, 2'b10, 4'd3, 4'd3, 16'h5AA5, 16'h5AA5, 16'h5AA5};

        // Reset, then Ready must rise exactly on the 16th edge.
        @(negedge Clock);
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 2'b00, 4'd0, 4'd0);
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b0, 1'b0, 1'b1, 4'(k), 16'hFFFF, 2'b11, 4'(k), 4'd3);
            chk("t1_ready", {31'd0, rdy1}, {31'd0, k == 16});
            chk("t1_rd", rd1, 32'h0);
        end

        foreach (vt[i]) begin
            cyc(1'b0, 1'b0, vt[i].wen, vt[i].wa, vt[i].wd, vt[i].wm,
                vt[i].a0, vt[i].a1);
            chk("vec_p0", {16'd0, rd1[15:0]},  {16'd0, vt[i].e0});
            chk("vec_p1", {16'd0, rd1[31:16]}, {16'd0, vt[i].e1});
            chk("vec_z0", {16'd0, rd0[15:0]},  {16'd0, vt[i].x0});
        end

        // Clear accepted; a write in the same cycle is lost; second Clear ignored.
        cyc(1'b0, 1'b1, 1'b1, 4'd9, 16'h7777, 2'b11, 4'd9, 4'd9);
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b0, k == 5, 1'b1, 4'd9, 16'h6666, 2'b11, 4'd9, 4'd9);
            chk("t6a_ready", {31'd0, rdy1}, {31'd0, k == 16});
        end
        idle(4'd9, 4'd3);
        chk("t6a_lost_wr", {16'd0, rd1[15:0]}, 32'h0);
        chk("t6a_cleared", {16'd0, rd1[31:16]}, 32'h0);

        // Reset at cycle 8 of a clear restarts the full sweep.
        cyc(1'b0, 1'b0, 1'b1, 4'd2, 16'h4321, 2'b11, 4'd2, 4'd2);
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 16'h0, 2'b00, 4'd2, 4'd2);
        for (int k = 1; k <= 7; k++) cyc(1'b0, k == 5, 1'b0, 4'd0, 16'h0, 2'b00, 4'd2, 4'd2);
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 2'b00, 4'd2, 4'd2);
        for (int k = 1; k <= 16; k++) begin
            idle(4'd2, 4'd2);
            chk("t6b_ready", {31'd0, rdy0}, {31'd0, k == 16});
        end
        for (int i = 0; i < 16; i += 2) begin
            idle(4'(i), 4'(i + 1));
            chk("t6b_zero", rd0, 32'h0);
        end

        // Randomised traffic against the model.
        for (int n = 0; n < 600; n++) begin
            cyc($urandom_range(0, 149) == 0, $urandom_range(0, 59) == 0,
                1'($urandom), 4'($urandom), 16'($urandom), 2'($urandom),
                4'($urandom), 4'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
